// File: rtl/panel_correct_pkg.sv
// Shared constants, types and helpers for the Panel Correction coefficient
// offset sequencer and its add/clamp datapath.
package panel_correct_pkg;

  localparam int N_COEF = 9;
  localparam int AW     = 4;
  localparam int DW     = 16;
  localparam int CW     = 13;
  localparam int SW     = CW + 2;
  localparam int RD_LAT = 1;

  localparam logic [AW-1:0] LAST_IDX = AW'(N_COEF - 1);
  localparam logic [AW-1:0] N_COEF_A = AW'(N_COEF);

  // Indices that sit on the optical axis, packed lowest index first.
  localparam int                      N_ON_AXIS    = 3;
  localparam logic [N_ON_AXIS*AW-1:0] ON_AXIS_LIST = {4'd8, 4'd4, 4'd0};

  localparam logic        [CW-1:0] ON_AXIS_MAX  = 13'h1FFF;
  localparam logic        [CW-1:0] ON_AXIS_MIN  = 13'h0000;
  localparam logic signed [SW-1:0] OFF_AXIS_MAX = 15'sd4095;
  localparam logic signed [SW-1:0] OFF_AXIS_MIN = -15'sd4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    CLS_OFF_AXIS = 1'b0,
    CLS_ON_AXIS  = 1'b1
  } coef_class_e;

  // Side-band tag carried with each element from read issue to write-back.
  typedef struct packed {
    logic        valid;
    logic [AW-1:0] idx;
    coef_class_e cls;
  } tag_t;

  function automatic coef_class_e coef_class(input logic [AW-1:0] idx);
    coef_class_e cls;
    cls = CLS_OFF_AXIS;
    for (int k = 0; k < N_ON_AXIS; k++) begin
      if (ON_AXIS_LIST[k*AW +: AW] == idx) cls = CLS_ON_AXIS;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pc_offset_sat_stage.sv
// Two-stage add/clamp datapath, one element per cycle, no stall: stage 1 adds
// the offset in 15 bits, stage 2 clamps according to the coefficient class.
module pc_offset_sat_stage
  import panel_correct_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [AW-1:0]   idx_i,
  input  coef_class_e     cls_i,
  input  logic [CW-1:0]   data_i,
  input  logic [CW-1:0]   ofs_i,
  output logic            valid_o,
  output logic [AW-1:0]   idx_o,
  output logic [DW-1:0]   data_o,
  output logic            sat_o,
  output logic            active_o
);

  logic [SW-1:0] data_ext;
  logic [SW-1:0] ofs_ext;
  logic [SW-1:0] sum_d;

  logic          s1_valid_q;
  logic [AW-1:0] s1_idx_q;
  coef_class_e   s1_cls_q;
  logic [SW-1:0] s1_sum_q;

  logic [CW-1:0] clamp_val;
  logic          clamp_sat;
  logic [DW-1:0] result_d;

  logic          s2_valid_q;
  logic [AW-1:0] s2_idx_q;
  logic [DW-1:0] s2_data_q;
  logic          s2_sat_q;

  // On-axis data is an unsigned magnitude; off-axis data is two's complement.
  always_comb begin
    // NOTE: every always_comb output gets an unconditional default first so no latch is inferred.
    data_ext = {{(SW-CW){data_i[CW-1]}}, data_i};
    if (cls_i == CLS_ON_AXIS) data_ext = {{(SW-CW){1'b0}}, data_i};
    ofs_ext = {{(SW-CW){ofs_i[CW-1]}}, ofs_i};
    sum_d   = data_ext + ofs_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with non-blocking assignments so all registers update together on the edge.
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_cls_q   <= CLS_OFF_AXIS;
      s1_sum_q   <= '0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_idx_q <= idx_i;
        s1_cls_q <= cls_i;
        s1_sum_q <= sum_d;
      end
    end
  end

  always_comb begin
    clamp_val = s1_sum_q[CW-1:0];
    clamp_sat = 1'b0;
    if (s1_cls_q == CLS_ON_AXIS) begin
      unique case (s1_sum_q[SW-1 -: 2])
        2'b00: clamp_sat = 1'b0;
        2'b01: begin
          clamp_val = ON_AXIS_MAX;
          clamp_sat = 1'b1;
        end
        default: begin
          clamp_val = ON_AXIS_MIN;
          clamp_sat = 1'b1;
        end
      endcase
    end else if ($signed(s1_sum_q) > OFF_AXIS_MAX) begin
      clamp_val = OFF_AXIS_MAX[CW-1:0];
      clamp_sat = 1'b1;
    end else if ($signed(s1_sum_q) < OFF_AXIS_MIN) begin
      clamp_val = OFF_AXIS_MIN[CW-1:0];
      clamp_sat = 1'b1;
    end
    result_d = {{(DW-CW){clamp_val[CW-1]}}, clamp_val};
    if (s1_cls_q == CLS_ON_AXIS) result_d = {{(DW-CW){1'b0}}, clamp_val};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_sat_q   <= s1_valid_q && clamp_sat;
      if (s1_valid_q) begin
        s2_idx_q  <= s1_idx_q;
        s2_data_q <= result_d;
      end
    end
  end

  assign valid_o  = s2_valid_q;
  assign idx_o    = s2_idx_q;
  assign data_o   = s2_data_q;
  assign sat_o    = s2_sat_q;
  assign active_o = s1_valid_q || s2_valid_q;

endmodule

// File: rtl/panel_correct_coef_sequencer.sv
// Runs one offset pass over the coefficient table: reads each entry, adds its
// per-index offset with saturation and writes the result back in place.
module panel_correct_coef_sequencer
  import panel_correct_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_start,
  output logic          busy,
  output logic          done,
  input  logic          ofs_we,
  input  logic [AW-1:0] ofs_addr,
  input  logic [DW-1:0] ofs_wdata,
  output logic          ofs_err,
  output logic          ram_rd,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic          ram_wr,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic [3:0]    sat_cnt
);

  state_e        state_q, state_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] ofs_q [N_COEF];
  tag_t          rtag_q [RD_LAT];
  logic          ofs_err_q;
  logic [3:0]    sat_cnt_q;

  logic          start_ok;
  logic          ofs_accept;
  logic          rtag_busy;
  logic          pipe_active;
  logic          pipe_empty;
  logic [CW-1:0] ofs_sel;
  logic          wr_sat;
  tag_t          rtag_out;

  // Only the 13-bit value fields of the offset and RAM buses carry information.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{ofs_wdata[DW-1:CW], ram_rdata[DW-1:CW]};

  assign start_ok   = (state_q == ST_IDLE) && cmd_start;
  assign ofs_accept = ofs_we && (state_q == ST_IDLE) && (ofs_addr < N_COEF_A);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) state_d = ST_READ;
      end
      ST_READ: begin
        if (rd_cnt_q == LAST_IDX) state_d = ST_DRAIN;
        else                      rd_cnt_d = rd_cnt_q + 1'b1;
      end
      ST_DRAIN: begin
        if (pipe_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; done fires in the first DRAIN cycle after the last write.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    ram_rd    = (state_q == ST_READ);
    ram_raddr = rd_cnt_q;
    done      = (state_q == ST_DRAIN) && pipe_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the offset file is reset element by element because a reset must clear every offset.
    if (!rst_n) begin
      for (int k = 0; k < N_COEF; k++) ofs_q[k] <= '0;
    end else if (ofs_accept) begin
      ofs_q[ofs_addr] <= ofs_wdata[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ofs_err_q <= 1'b0;
    else        ofs_err_q <= ofs_we && !ofs_accept;
  end

  assign ofs_err = ofs_err_q;

  // Tag delay line matching the RAM read latency so index and class meet rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) rtag_q[k] <= '0;
    end else begin
      rtag_q[0] <= '{valid: ram_rd, idx: rd_cnt_q, cls: coef_class(rd_cnt_q)};
      for (int k = 1; k < RD_LAT; k++) rtag_q[k] <= rtag_q[k-1];
    end
  end

  always_comb begin
    rtag_busy = 1'b0;
    for (int k = 0; k < RD_LAT; k++) rtag_busy = rtag_busy || rtag_q[k].valid;
    rtag_out = rtag_q[RD_LAT-1];
    ofs_sel  = '0;
    if (rtag_out.valid) ofs_sel = ofs_q[rtag_out.idx];
  end

  assign pipe_empty = !rtag_busy && !pipe_active;

  pc_offset_sat_stage u_sat_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (rtag_out.valid),
    .idx_i    (rtag_out.idx),
    .cls_i    (rtag_out.cls),
    .data_i   (ram_rdata[CW-1:0]),
    .ofs_i    (ofs_sel),
    .valid_o  (ram_wr),
    .idx_o    (ram_waddr),
    .data_o   (ram_wdata),
    .sat_o    (wr_sat),
    .active_o (pipe_active)
  );

  // Saturation counter for the current pass, sticky at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (start_ok) begin
      sat_cnt_q <= '0;
    end else if (ram_wr && wr_sat && (sat_cnt_q != 4'hF)) begin
      sat_cnt_q <= sat_cnt_q + 4'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_panel_correct_coef_sequencer.sv
// Directed bench for the coefficient offset sequencer with a 1-cycle-latency
// RAM model, a negedge activity logger and hand-computed expectations.
module tb_panel_correct_coef_sequencer;
  import panel_correct_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_start = 1'b0;
  logic          busy, done;
  logic          ofs_we = 1'b0;
  logic [AW-1:0] ofs_addr = '0;
  logic [DW-1:0] ofs_wdata = '0;
  logic          ofs_err;
  logic          ram_rd;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_wr;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [3:0]    sat_cnt;

  panel_correct_coef_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_start (cmd_start),
    .busy      (busy),
    .done      (done),
    .ofs_we    (ofs_we),
    .ofs_addr  (ofs_addr),
    .ofs_wdata (ofs_wdata),
    .ofs_err   (ofs_err),
    .ram_rd    (ram_rd),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_wr    (ram_wr),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient RAM model: read data valid one cycle after ram_rd.
  logic [15:0] mem [16];
  logic [15:0] img [16];
  logic        load = 1'b0;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
    end else if (ram_wr) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (ram_rd) ram_rdata <= mem[ram_raddr];
  end

  // Activity log sampled mid-cycle
  int          rd_n = 0, wr_n = 0, done_n = 0, busy_n = 0, viol = 0, done_cyc = 0;
  int          rd_cyc [64];
  int          wr_cyc [64];
  logic [3:0]  rd_addr_log [64];
  logic [3:0]  wr_addr_log [64];
  logic [15:0] wr_data_log [64];
  always @(negedge clk) begin
    if (ram_rd && rd_n < 64) begin
      rd_cyc[rd_n] = cyc;
      rd_addr_log[rd_n] = ram_raddr;
      rd_n++;
    end
    if (ram_wr && wr_n < 64) begin
      wr_cyc[wr_n] = cyc;
      wr_addr_log[wr_n] = ram_waddr;
      wr_data_log[wr_n] = ram_wdata;
      wr_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (busy) busy_n++;
    if ((ram_rd || ram_wr) && !busy) viol++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ofs_write(input logic [3:0] a, input logic [15:0] d);
    ofs_we    = 1'b1;
    ofs_addr  = a;
    ofs_wdata = d;
    tick();
    ofs_we    = 1'b0;
  endtask

  task automatic load_mem();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = done_n;
    for (int i = 0; i < budget; i++) begin
      if (done_n != n0) break;
      tick();
    end
    check("done_seen", 32'(done_n != n0), 32'd1);
  endtask

  logic [15:0] exp_d [9];
  int t0, br, bw, bd, bb, ok;

  initial begin
    for (int i = 0; i < 16; i++) img[i] = '0;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_ofserr", 32'(ofs_err),   32'd0);
    check("rst_ram_rd", 32'(ram_rd),    32'd0);
    check("rst_ram_wr", 32'(ram_wr),    32'd0);
    check("rst_raddr",  32'(ram_raddr), 32'd0);
    check("rst_waddr",  32'(ram_waddr), 32'd0);
    check("rst_wdata",  32'(ram_wdata), 32'd0);
    check("rst_satcnt", 32'(sat_cnt),   32'd0);

    // Out-of-range offset write is rejected with a one-cycle error pulse
    for (int i = 0; i < 9; i++) img[i] = 16'(i * 16'h0111);
    load_mem();
    ofs_write(4'd9, 16'h0050);
    check("err_addr9", 32'(ofs_err), 32'd1);
    tick();
    check("err_addr9_pulse", 32'(ofs_err), 32'd0);

    // Timing pass, offsets all zero, with a busy offset write and a second start
    br = rd_n; bw = wr_n; bd = done_n; bb = busy_n;
    t0 = cyc;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    ofs_write(4'd7, 16'h0050);
    check("err_busy", 32'(ofs_err), 32'd1);
    tick();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wait_done(30);
    repeat (12) tick();
    check("rd_count",    32'(rd_n - br),       32'd9);
    check("rd_first",    32'(rd_cyc[br]),      32'(t0 + 1));
    check("rd_last",     32'(rd_cyc[br + 8]),  32'(t0 + 9));
    check("wr_count",    32'(wr_n - bw),       32'd9);
    check("wr_first",    32'(wr_cyc[bw]),      32'(t0 + 4));
    check("wr_last",     32'(wr_cyc[bw + 8]),  32'(t0 + 12));
    check("done_cyc",    32'(done_cyc),        32'(t0 + 13));
    check("done_count",  32'(done_n - bd),     32'd1);
    check("busy_cycles", 32'(busy_n - bb),     32'd13);
    ok = 0;
    for (int i = 0; i < 9; i++) begin
      if (rd_addr_log[br + i] === 4'(i) && wr_addr_log[bw + i] === 4'(i) &&
          wr_data_log[bw + i] === img[i]) ok++;
    end
    check("pass_unchanged", 32'(ok), 32'd9);
    check("sat_zero", 32'(sat_cnt), 32'd0);

    // Saturation pass; offset 7 is written in the same cycle as the start
    img[0] = 16'h1388; img[1] = 16'h0FFA; img[2] = 16'hF002;
    img[3] = 16'hFFFF; img[4] = 16'h1FA4; img[5] = 16'h0123;
    img[6] = 16'h0ABC; img[7] = 16'h0777; img[8] = 16'h0064;
    exp_d[0] = 16'h13EC; exp_d[1] = 16'h0FFF; exp_d[2] = 16'hF000;
    exp_d[3] = 16'hFFFF; exp_d[4] = 16'h1FFF; exp_d[5] = 16'h0123;
    exp_d[6] = 16'h0ABC; exp_d[7] = 16'h0787; exp_d[8] = 16'h0000;
    load_mem();
    ofs_write(4'd0, 16'h0064);
    ofs_write(4'd1, 16'h000A);
    ofs_write(4'd2, 16'h1FFB);
    ofs_write(4'd4, 16'h00C8);
    ofs_write(4'd8, 16'h1ED4);
    bw = wr_n;
    cmd_start = 1'b1;
    ofs_we    = 1'b1;
    ofs_addr  = 4'd7;
    ofs_wdata = 16'h0010;
    tick();
    cmd_start = 1'b0;
    ofs_we    = 1'b0;
    check("start_write_ok", 32'(ofs_err), 32'd0);
    wait_done(30);
    tick();
    check("sat_wr_count", 32'(wr_n - bw), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("sat_wdata%0d", i), 32'(wr_data_log[bw + i]), 32'(exp_d[i]));
    end
    check("sat_cnt4", 32'(sat_cnt), 32'd4);

    // Reset in the middle of a pass
    load_mem();
    t0 = cyc;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy),   32'd0);
    check("mid_rst_ramwr", 32'(ram_wr), 32'd0);
    check("mid_rst_done",  32'(done),   32'd0);
    br = rd_n; bw = wr_n; bd = done_n;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("abort_no_rd",   32'(rd_n - br),   32'd0);
    check("abort_no_wr",   32'(wr_n - bw),   32'd0);
    check("abort_no_done", 32'(done_n - bd), 32'd0);
    check("abort_satcnt",  32'(sat_cnt),     32'd0);

    // Fresh pass after reset: offsets were cleared so data comes back unchanged
    load_mem();
    br = rd_n; bw = wr_n; bd = done_n;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wait_done(30);
    tick();
    check("post_rst_rd",   32'(rd_n - br),   32'd9);
    check("post_rst_wr",   32'(wr_n - bw),   32'd9);
    check("post_rst_done", 32'(done_n - bd), 32'd1);
    ok = 0;
    for (int i = 0; i < 9; i++) begin
      if (wr_addr_log[bw + i] === 4'(i) && wr_data_log[bw + i] === img[i]) ok++;
    end
    check("post_rst_data", 32'(ok), 32'd9);
    check("no_io_outside_busy", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
